// File: rtl/flit_injector.sv
`default_nettype none
// ============================================================================
// Module  : flit_injector (with package noc_params)
// Purpose : Network-interface transmitter feeding a router's local input port.
//           Accepts packet descriptors plus payload words from the local core,
//           claims a free downstream VC round-robin, and emits HEAD/BODY/TAIL
//           (or HEADTAIL) flits tagged with that VC while its on/off is high.
// Ports   : clk, rst             clock, asynchronous active-high reset
//           pkt_valid_i/ready_o  descriptor handshake (pkt_len_i, head_data_i)
//           pld_valid_i/ready_o  payload handshake (pld_data_i)
//           on_off_i             per-VC flow control from downstream
//           vc_allocatable_i     per-VC release pulse from downstream
//           flit_o/flit_valid_o  registered flit output and write strobe
//           error_o              registered one-cycle protocol-error pulse
// Revision: 1.0  initial release
// ============================================================================

package noc_params;
    localparam int VC_NUM  = 4;
    localparam int VC_SIZE = 8;
    localparam int DATA_W  = 16;
    localparam int VC_W    = $clog2(VC_NUM);

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef struct packed {
        flit_label_t       label;
        logic [VC_W-1:0]   vc_id;
        logic [DATA_W-1:0] data;
    } flit_t;
endpackage

module flit_injector
    import noc_params::*;
#(
    parameter int LEN_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pkt_valid_i,
    output logic                pkt_ready_o,
    input  logic [LEN_W-1:0]    pkt_len_i,
    input  logic [DATA_W-1:0]   head_data_i,
    input  logic                pld_valid_i,
    input  logic [DATA_W-1:0]   pld_data_i,
    output logic                pld_ready_o,
    input  logic [VC_NUM-1:0]   on_off_i,
    input  logic [VC_NUM-1:0]   vc_allocatable_i,
    output flit_t               flit_o,
    output logic                flit_valid_o,
    output logic                error_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HEAD = 2'd1,
        S_BODY = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [VC_NUM-1:0]   busy;
    logic [VC_NUM-1:0]   busy_next;
    logic [VC_W-1:0]     rr_ptr;
    logic [VC_W-1:0]     cur_vc;
    logic [LEN_W-1:0]    remaining;
    logic [DATA_W-1:0]   head_data;

    logic [VC_W-1:0]     sel_vc;
    logic                sel_found;
    logic [VC_W-1:0]     cand;

    logic                load;
    logic                dec;
    logic                send;
    flit_t               send_flit;
    logic                err_state;
    logic                err_len0;
    logic                error_next;

    // Round-robin search starting just after the last granted VC, wrapping.
    always_comb begin
        sel_vc    = '0;
        sel_found = 1'b0;
        cand      = '0;
        for (int i = 1; i <= VC_NUM; i++) begin
            cand = VC_W'((int'(rr_ptr) + i) % VC_NUM);
            if (!sel_found && !busy[cand]) begin
                sel_vc    = cand;
                sel_found = 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and handshake/send decisions
    always_comb begin
        state_next      = state;
        pkt_ready_o     = 1'b0;
        pld_ready_o     = 1'b0;
        load            = 1'b0;
        dec             = 1'b0;
        send            = 1'b0;
        send_flit       = '0;
        send_flit.vc_id = cur_vc;
        err_state       = 1'b0;
        err_len0        = 1'b0;
        case (state)
            S_IDLE: begin
                // Held low while rst is asserted even though state is IDLE.
                pkt_ready_o = !rst && sel_found;
                if (pkt_valid_i && pkt_ready_o) begin
                    if (pkt_len_i == '0) begin
                        // Zero-length descriptor is dropped without claiming a VC.
                        err_len0 = 1'b1;
                    end else begin
                        load       = 1'b1;
                        state_next = S_HEAD;
                    end
                end
            end
            S_HEAD: begin
                if (on_off_i[cur_vc]) begin
                    send           = 1'b1;
                    dec            = 1'b1;
                    send_flit.data = head_data;
                    if (remaining == LEN_W'(1)) begin
                        send_flit.label = HEADTAIL;
                        state_next      = S_IDLE;
                    end else begin
                        send_flit.label = HEAD;
                        state_next      = S_BODY;
                    end
                end
            end
            S_BODY: begin
                pld_ready_o = on_off_i[cur_vc];
                if (pld_valid_i && on_off_i[cur_vc]) begin
                    send           = 1'b1;
                    dec            = 1'b1;
                    send_flit.data = pld_data_i;
                    if (remaining == LEN_W'(1)) begin
                        send_flit.label = TAIL;
                        state_next      = S_IDLE;
                    end else begin
                        send_flit.label = BODY;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
                err_state  = 1'b1;
            end
        endcase
    end

    // Releases clear busy bits unconditionally (even the VC in flight);
    // a new grant sets its bit. The two never target the same VC together.
    always_comb begin
        busy_next = busy & ~vc_allocatable_i;
        if (load) begin
            busy_next = busy_next | (VC_NUM'(1) << sel_vc);
        end
    end

    // Error sources: dropped zero-length descriptor, release of a free VC,
    // release of the VC still being transmitted, and a corrupt state code.
    always_comb begin
        error_next = err_state || err_len0
                  || (|(vc_allocatable_i & ~busy))
                  || (((state == S_HEAD) || (state == S_BODY)) && vc_allocatable_i[cur_vc]);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy         <= '0;
            rr_ptr       <= VC_W'(VC_NUM - 1);
            cur_vc       <= '0;
            remaining    <= '0;
            head_data    <= '0;
            flit_o       <= '0;
            flit_valid_o <= 1'b0;
            error_o      <= 1'b0;
        end else begin
            busy <= busy_next;
            if (load) begin
                rr_ptr    <= sel_vc;
                cur_vc    <= sel_vc;
                remaining <= pkt_len_i;
                head_data <= head_data_i;
            end else if (dec) begin
                remaining <= remaining - LEN_W'(1);
            end
            flit_valid_o <= send;
            flit_o       <= send ? send_flit : '0;
            error_o      <= error_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_flit_injector.sv
`default_nettype none
// ============================================================================
// Module  : tb_flit_injector
// Purpose : Directed, self-checking bench for flit_injector. A table of packet
//           records (length, head data, payload base, expected VC, stall
//           window) drives the main traffic; short hand-written sequences
//           cover release, error and mid-packet reset cases.
// Revision: 1.0  initial release
// ============================================================================
module tb_flit_injector;
    import noc_params::*;

    localparam int LEN_W = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                pkt_valid_i;
    logic                pkt_ready_o;
    logic [LEN_W-1:0]    pkt_len_i;
    logic [DATA_W-1:0]   head_data_i;
    logic                pld_valid_i;
    logic [DATA_W-1:0]   pld_data_i;
    logic                pld_ready_o;
    logic [VC_NUM-1:0]   on_off_i;
    logic [VC_NUM-1:0]   vc_allocatable_i;
    flit_t               flit_o;
    logic                flit_valid_o;
    logic                error_o;

    int n_cmp = 0;
    int n_err = 0;

    flit_injector #(.LEN_W(LEN_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .pkt_valid_i      (pkt_valid_i),
        .pkt_ready_o      (pkt_ready_o),
        .pkt_len_i        (pkt_len_i),
        .head_data_i      (head_data_i),
        .pld_valid_i      (pld_valid_i),
        .pld_data_i       (pld_data_i),
        .pld_ready_o      (pld_ready_o),
        .on_off_i         (on_off_i),
        .vc_allocatable_i (vc_allocatable_i),
        .flit_o           (flit_o),
        .flit_valid_o     (flit_valid_o),
        .error_o          (error_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              len;
        logic [15:0]     head;
        logic [15:0]     base;
        int              vc;
        int              stall_at;
        int              stall_n;
    } pkt_vec_t;

    pkt_vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one packet described by v and checks every flit it produces.
    task automatic run_pkt(input pkt_vec_t v, input string nm);
        int          t;
        int          got;
        int          idx;
        int          c;
        int          pr_cnt;
        int          first_c;
        logic        stalled;
        logic        consumed;
        flit_label_t exp_lab;
        logic [15:0] exp_dat;

        on_off_i    = '1;
        pkt_valid_i = 1'b1;
        pkt_len_i   = LEN_W'(v.len);
        head_data_i = v.head;
        #1;
        t = 0;
        while (!pkt_ready_o && t < 20) begin
            tick();
            t++;
        end
        check({nm, "_pkt_ready"}, 32'(pkt_ready_o), 32'd1);
        tick();
        pkt_valid_i = 1'b0;

        got = 0; idx = 0; c = 1; pr_cnt = 0; first_c = 0;
        pld_valid_i = 1'b1;
        pld_data_i  = v.base;
        while (got < v.len && c < 60) begin
            stalled  = (c >= v.stall_at) && (c < v.stall_at + v.stall_n);
            on_off_i = stalled ? ~(VC_NUM'(1) << v.vc) : '1;
            #1;
            if (stalled) check({nm, "_stall_pld_ready"}, 32'(pld_ready_o), 32'd0);
            if (pld_ready_o) pr_cnt++;
            consumed = pld_ready_o && pld_valid_i;
            tick();
            if (consumed) begin
                idx++;
                pld_data_i = v.base + 16'(idx);
            end
            c++;
            if (stalled) check({nm, "_stall_no_flit"}, 32'(flit_valid_o), 32'd0);
            if (flit_valid_o) begin
                if (v.len == 1)           exp_lab = HEADTAIL;
                else if (got == 0)        exp_lab = HEAD;
                else if (got == v.len-1)  exp_lab = TAIL;
                else                      exp_lab = BODY;
                exp_dat = (got == 0) ? v.head : v.base + 16'(got - 1);
                check({nm, "_label"}, 32'(flit_o.label), 32'(exp_lab));
                check({nm, "_vc"},    32'(flit_o.vc_id), 32'(v.vc));
                check({nm, "_data"},  32'(flit_o.data),  32'(exp_dat));
                if (got == 0) first_c = c;
                got++;
            end
        end
        pld_valid_i = 1'b0;
        on_off_i    = '1;
        check({nm, "_flit_count"}, 32'(got), 32'(v.len));
        if (v.stall_n == 0 || v.stall_at > 1)
            check({nm, "_head_latency"}, 32'(first_c), 32'd2);
        check({nm, "_last_cycle"}, 32'(c), 32'(1 + v.len + v.stall_n));
        check({nm, "_pld_ready_cycles"}, 32'(pr_cnt), 32'(v.len - 1));
        check({nm, "_no_error"}, 32'(error_o), 32'd0);
    endtask

    initial begin
        tbl[0] = '{1, 16'h00A5, 16'h0000, 0, 0, 0};   // single flit
        tbl[1] = '{4, 16'h0010, 16'h0001, 1, 0, 0};   // 4-flit, payload 1,2,3
        tbl[2] = '{2, 16'h0020, 16'h0030, 2, 0, 0};
        tbl[3] = '{3, 16'h0022, 16'h0040, 3, 0, 0};   // last free VC
        tbl[4] = '{2, 16'h0033, 16'h0060, 1, 0, 0};   // reuses released VC 1
        tbl[5] = '{4, 16'h0040, 16'h0050, 2, 3, 3};   // backpressure mid-BODY
        tbl[6] = '{1, 16'h0077, 16'h0000, 3, 0, 0};   // after len=0 drop
        tbl[7] = '{2, 16'h0099, 16'h00C0, 0, 0, 0};   // first packet after reset

        rst = 1'b1;
        pkt_valid_i = 1'b0; pkt_len_i = '0; head_data_i = '0;
        pld_valid_i = 1'b0; pld_data_i = '0;
        on_off_i = '1; vc_allocatable_i = '0;
        tick();
        check("rst_pkt_ready",  32'(pkt_ready_o),  32'd0);
        check("rst_flit_valid", 32'(flit_valid_o), 32'd0);
        check("rst_flit",       32'(flit_o),       32'd0);
        check("rst_error",      32'(error_o),      32'd0);
        check("rst_pld_ready",  32'(pld_ready_o),  32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_pkt_ready", 32'(pkt_ready_o), 32'd1);

        // Fill all VCs round-robin with no releases.
        for (int i = 0; i < 4; i++) begin
            run_pkt(tbl[i], $sformatf("pkt%0d", i));
            if (i < 3) check($sformatf("pkt%0d_ready_after", i), 32'(pkt_ready_o), 32'd1);
        end
        check("exhausted_pkt_ready", 32'(pkt_ready_o), 32'd0);

        // Release VC 1: selectable only from the following cycle.
        vc_allocatable_i = 4'b0010;
        #1;
        check("release_same_cycle_ready", 32'(pkt_ready_o), 32'd0);
        tick();
        vc_allocatable_i = '0;
        #1;
        check("release_next_cycle_ready", 32'(pkt_ready_o), 32'd1);
        check("release_legal_no_error",   32'(error_o),     32'd0);
        run_pkt(tbl[4], "pkt4");

        // Free everything (all busy, so no error).
        vc_allocatable_i = 4'b1111;
        tick();
        vc_allocatable_i = '0;
        check("release_all_no_error", 32'(error_o), 32'd0);

        run_pkt(tbl[5], "bp");

        // Zero-length descriptor: dropped, error pulse, no VC claimed.
        pkt_valid_i = 1'b1;
        pkt_len_i   = '0;
        #1;
        check("len0_ready", 32'(pkt_ready_o), 32'd1);
        tick();
        pkt_valid_i = 1'b0;
        check("len0_error_pulse", 32'(error_o),      32'd1);
        check("len0_no_flit",     32'(flit_valid_o), 32'd0);
        tick();
        check("len0_error_clear", 32'(error_o),      32'd0);
        check("len0_no_flit2",    32'(flit_valid_o), 32'd0);
        check("len0_still_idle",  32'(pkt_ready_o),  32'd1);
        run_pkt(tbl[6], "after_len0");

        // Spurious release of free VC 0.
        vc_allocatable_i = 4'b0001;
        tick();
        vc_allocatable_i = '0;
        check("spurious_error_pulse", 32'(error_o), 32'd1);
        tick();
        check("spurious_error_clear", 32'(error_o), 32'd0);

        // Reset in the middle of a 6-flit packet.
        on_off_i    = '1;
        pkt_valid_i = 1'b1;
        pkt_len_i   = LEN_W'(6);
        head_data_i = 16'h00E0;
        #1;
        check("mid_rst_accept_ready", 32'(pkt_ready_o), 32'd1);
        tick();
        pkt_valid_i = 1'b0;
        pld_valid_i = 1'b1;
        pld_data_i  = 16'h00E1;
        tick();
        tick();
        check("mid_rst_in_body", 32'(pld_ready_o), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_flit_valid", 32'(flit_valid_o), 32'd0);
        check("mid_rst_flit",       32'(flit_o),       32'd0);
        check("mid_rst_pkt_ready",  32'(pkt_ready_o),  32'd0);
        check("mid_rst_pld_ready",  32'(pld_ready_o),  32'd0);
        tick();
        rst = 1'b0;
        pld_valid_i = 1'b0;
        #1;
        check("after_rst_ready", 32'(pkt_ready_o), 32'd1);
        run_pkt(tbl[7], "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/flit_injector.md
# flit_injector

Network-interface transmitter that feeds a router's local input port: it takes packet descriptors and payload words from the local core and splits them into HEAD/BODY/TAIL (or HEADTAIL) flits. For each packet it claims a free virtual channel of the downstream input port and tags every flit with that VC. It sends a flit only while that VC's on/off signal is on. A VC is released when the downstream input port reports it allocatable again.

## Interface
- LEN_W, 4: width of packet length field; max packet = 2^LEN_W-1 flits
- VC_NUM, VC_SIZE, flit_t, flit_label values: from noc_params
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- pkt_valid_i  in  1  descriptor valid
- pkt_ready_o  out  1  descriptor accepted when valid & ready
- pkt_len_i  in  LEN_W  flit count of packet, 1..2^LEN_W-1
- head_data_i  in  flit data width  data field of head flit
- pld_valid_i  in  1  payload word valid
- pld_data_i  in  flit data width  data field of next body/tail flit
- pld_ready_o  out  1  payload word consumed when valid & ready
- on_off_i  in  VC_NUM  per-VC flow control from downstream; 1 = may send
- vc_allocatable_i  in  VC_NUM  per-VC single-cycle release pulse from downstream
- flit_o  out  flit_t  flit with label, vc_id, data
- flit_valid_o  out  1  flit_o valid (write strobe downstream)
- error_o  out  1  registered protocol-error pulse

## Operation
- Per-VC busy bits, reset 0.
  - Set when a descriptor is accepted on that VC.
  - Cleared on vc_allocatable_i[v].
- VC selection is round-robin. It searches from rr_ptr+1 upward, wrapping, for the first VC with busy=0. rr_ptr (reset VC_NUM-1) updates to the chosen VC on acceptance.
- FSM states: IDLE, HEAD, BODY.
  - IDLE: pkt_ready_o = 1 iff any busy bit is 0. On accept: latch len, head_data_i and the chosen VC; set busy; go to HEAD.
  - HEAD: sends when on_off_i[vc]=1. Label is HEADTAIL if len==1, otherwise HEAD. Then: len==1 -> IDLE; otherwise remaining = len-1 -> BODY.
  - BODY: pld_ready_o = on_off_i[vc]. A flit is sent on pld_valid_i & on_off_i[vc]. Label is TAIL if remaining==1 (-> IDLE), otherwise BODY (remaining decrements).
- pkt_ready_o is 0 outside IDLE. pld_ready_o is 0 outside BODY.
- pkt_len_i==0 when accepted: the descriptor is consumed, no flit is sent, no VC is claimed, error_o pulses, and the FSM stays in IDLE.
- vc_allocatable_i[v] for a VC with busy=0: error_o pulses and the bit stays 0.
- vc_allocatable_i on the VC currently being transmitted (before the tail is sent): error_o pulses and the bit is cleared anyway. Transmission continues.
- Illegal state encoding: go to IDLE, pulse error_o.

## Timing
- Reset values: pkt_ready_o=0 during rst, busy=0, state IDLE, flit_o=0, flit_valid_o=0, error_o=0.
- pkt_ready_o and pld_ready_o are combinational from state, busy and on_off_i.
- flit_o and flit_valid_o are registered: a send decided in cycle n appears in cycle n+1 for exactly one cycle. flit_valid_o=0 when nothing is sent.
- Latency: descriptor accepted in cycle n -> HEAD state in n+1 -> head flit visible in n+2, if on_off is high.
- Throughput: one flit per cycle while on_off stays high and payload is valid.
  - Back-to-back packets lose one cycle: the tail send cycle returns to IDLE, and the next accept occurs in IDLE.
- on_off_i is sampled in the send cycle only. Downstream slack covers the one-cycle output register.
- Busy set and release use the registered busy vector.
  - A release in cycle n makes the VC selectable in cycle n+1.
  - A release and an allocation of the same VC never coincide.
- error_o is a one-cycle pulse one cycle after the offending event.
- rst mid-packet abandons the packet. No tail is generated, and all VCs are marked free.

## Test plan
- Single-flit packet: len=1, head_data=0xA5, on_off=all 1 -> one flit in cycle n+2, label HEADTAIL, vc_id=0, data=0xA5. busy[0] set; pkt_ready_o stays 1 while other VCs are free.
- 4-flit packet, payload 1,2,3 always valid -> flits HEAD, BODY(1), BODY(2), TAIL(3) in consecutive cycles on one VC. pld_ready_o is high for 3 cycles.
- Backpressure: drop on_off_i[vc] for 3 cycles mid-BODY -> no flit_valid_o and no pld_ready_o for those cycles. Order and labels are preserved after resume.
- VC exhaustion: VC_NUM packets with no releases -> VCs allocated 0,1,2,... round-robin, then pkt_ready_o=0. Pulse vc_allocatable_i[1] -> pkt_ready_o=1 next cycle and the next packet uses VC 1.
- Errors: len=0 descriptor -> error_o pulse, no flits. Spurious vc_allocatable_i on a free VC -> error_o pulse.
- Reset mid-BODY of a 6-flit packet -> outputs 0 and all VCs free. The next packet after reset starts with HEAD on VC 0.
